// File: rtl/tpu_pkg.sv
// Shared TPU definitions: partial-sum geometry, the result-readout FSM
// encoding and the signed partial-sum element type.
package tpu_pkg;

  localparam int PARTIAL_SUM_BW = 24;
  localparam int MATRIX_SIZE    = 16;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    LATCH,
    STREAM,
    FIN
  } readout_state_t;

  typedef logic signed [PARTIAL_SUM_BW-1:0] ps_t;

endpackage

// File: rtl/result_row_serializer.sv
// Serializes one latched result row into MATRIX_SIZE partial-sum words on a
// valid/ready stream. Build option RESULT_RELU_EN clamps negative words to 0.
module result_row_serializer #(
  parameter int PARTIAL_SUM_BW = 24,
  parameter int MATRIX_SIZE    = 16,
  parameter int ELEM_W         = $clog2(MATRIX_SIZE) + 1
) (
  input  logic                                  clk,
  input  logic                                  rstn,
  input  logic                                  load,
  input  logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0] row_data,
  input  logic                                  is_last_row,
  input  logic                                  m_ready,
  output logic                                  m_valid,
  output logic [PARTIAL_SUM_BW-1:0]             m_data,
  output logic                                  m_last,
  output logic                                  row_done
);

  localparam int                ROW_W     = PARTIAL_SUM_BW * MATRIX_SIZE;
  localparam logic [ELEM_W-1:0] LAST_ELEM = ELEM_W'(MATRIX_SIZE - 1);

  logic [ROW_W-1:0]          r_shift;
  logic [ELEM_W-1:0]         r_elem;
  logic                      r_valid;
  logic                      w_handshake;
  logic                      w_elem_last;
  logic [PARTIAL_SUM_BW-1:0] w_elem;

  assign w_handshake = r_valid & m_ready;
  assign w_elem_last = (r_elem == LAST_ELEM);
  assign row_done    = w_handshake & w_elem_last;
  assign w_elem      = r_shift[PARTIAL_SUM_BW-1:0];

  // NOTE: the row register is reset even though it is a data store, because
  // m_data is taken straight from its low element and must read 0 after reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_shift <= '0;
      r_elem  <= '0;
      r_valid <= 1'b0;
    end else if (load) begin
      r_shift <= row_data;
      r_elem  <= '0;
      r_valid <= 1'b1;
    end else if (w_handshake) begin
      r_shift <= r_shift >> PARTIAL_SUM_BW;
      if (w_elem_last) begin
        r_elem  <= '0;
        r_valid <= 1'b0;
      end else begin
        r_elem <= r_elem + ELEM_W'(1);
      end
    end
  end

  assign m_valid = r_valid;
  assign m_last  = r_valid & is_last_row & w_elem_last;

  always_comb begin
`ifdef RESULT_RELU_EN
    m_data = w_elem[PARTIAL_SUM_BW-1] ? '0 : w_elem;
`else
    m_data = w_elem;
`endif
  end

endmodule

// File: rtl/result_readout_ctrl.sv
// Drains NUM_ROWS result rows from the result SRAM starting at BASE_ADDR and
// streams them word by word. Optional build macro: RESULT_RELU_EN.
module result_readout_ctrl #(
  parameter int                     ADDRESSSIZE    = 10,
  parameter int                     PARTIAL_SUM_BW = tpu_pkg::PARTIAL_SUM_BW,
  parameter int                     MATRIX_SIZE    = tpu_pkg::MATRIX_SIZE,
  parameter int                     NUM_ROWS       = 16,
  parameter logic [ADDRESSSIZE-1:0] BASE_ADDR      = '0
) (
  input  logic                                  clk,
  input  logic                                  rstn,
  input  logic                                  start,
  output logic [ADDRESSSIZE-1:0]                sram_address,
  input  logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0] sram_data_in,
  output logic                                  m_valid,
  input  logic                                  m_ready,
  output logic [PARTIAL_SUM_BW-1:0]             m_data,
  output logic                                  m_last,
  output logic                                  busy,
  output logic                                  done
);

  import tpu_pkg::*;

  localparam int            ROW_W    = $clog2(NUM_ROWS) + 1;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROWS - 1);

  readout_state_t   r_state;
  readout_state_t   w_next_state;
  logic [ROW_W-1:0] r_row;
  logic             w_last_row;
  logic             w_row_done;
  logic             w_load;

  assign w_last_row = (r_row == LAST_ROW);
  assign w_load     = (r_state == LATCH);

  // Address wraps naturally at ADDRESSSIZE bits.
  assign sram_address = BASE_ADDR + ADDRESSSIZE'(r_row);

  // NOTE: state and counters use non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_row   <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == FIN) begin
        r_row <= '0;
      end else if (w_row_done && !w_last_row) begin
        r_row <= r_row + ROW_W'(1);
      end
    end
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    w_next_state = r_state;
    busy         = 1'b1;
    done         = 1'b0;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (start) w_next_state = READ;
      end
      READ:  w_next_state = LATCH;
      LATCH: w_next_state = STREAM;
      STREAM: begin
        if (w_row_done) w_next_state = w_last_row ? FIN : READ;
      end
      FIN: begin
        done         = 1'b1;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  result_row_serializer #(
    .PARTIAL_SUM_BW(PARTIAL_SUM_BW),
    .MATRIX_SIZE   (MATRIX_SIZE)
  ) u_serializer (
    .clk        (clk),
    .rstn       (rstn),
    .load       (w_load),
    .row_data   (sram_data_in),
    .is_last_row(w_last_row),
    .m_ready    (m_ready),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_last     (m_last),
    .row_done   (w_row_done)
  );

endmodule

// File: tb/tb_result_readout_ctrl.sv
// Scoreboard bench for result_readout_ctrl: randomized SRAM contents and
// backpressure, expected stream derived row/element-wise from the SRAM image.
module tb_result_readout_ctrl;

  import tpu_pkg::*;

  localparam int AW           = 10;
  localparam int PSW          = PARTIAL_SUM_BW;
  localparam int MS           = MATRIX_SIZE;
  localparam int NR           = 16;
  localparam int ROWW         = PSW * MS;
  localparam logic [AW-1:0] BASE = '0;
  localparam int DRAIN_CYCLES = NR * (MS + 2);
`ifdef RESULT_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  logic            clk;
  logic            rstn;
  logic            start;
  logic [AW-1:0]   sram_address;
  logic [ROWW-1:0] sram_data_in;
  logic            m_valid;
  logic            m_ready;
  logic [PSW-1:0]  m_data;
  logic            m_last;
  logic            busy;
  logic            done;

  result_readout_ctrl #(
    .ADDRESSSIZE   (AW),
    .PARTIAL_SUM_BW(PSW),
    .MATRIX_SIZE   (MS),
    .NUM_ROWS      (NR),
    .BASE_ADDR     (BASE)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .start       (start),
    .sram_address(sram_address),
    .sram_data_in(sram_data_in),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .m_last      (m_last),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [PSW-1:0] data;
    logic           last;
  } beat_t;

  beat_t           exp_q[$];
  beat_t           mon_b;
  logic [ROWW-1:0] mem [0:(1<<AW)-1];
  logic [AW-1:0]   addr_seen[$];
  int              n_checks = 0;
  int              n_errors = 0;
  int              cyc = 0;
  int              done_cnt = 0;
  int              words = 0;
  int              start_edge = 0;
  bit              lat_check = 1'b0;
  int              ready_mode = 0;
  int              ready_phase = 0;
  logic            prev_stall = 1'b0;
  logic [PSW-1:0]  prev_data;
  logic            prev_last;

  // Synchronous-read SRAM model, one cycle of latency.
  always @(posedge clk) sram_data_in <= mem[sram_address];
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every handshake, checks stall stability and done.
  always @(negedge clk) begin
    if (!rstn) begin
      prev_stall = 1'b0;
    end else begin
      if (busy && (addr_seen.size() == 0 || sram_address != addr_seen[addr_seen.size()-1]))
        addr_seen.push_back(sram_address);
      if (m_valid && prev_stall) begin
        check("stall_data", m_data, prev_data);
        check("stall_last", m_last, prev_last);
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_word: got %0h with nothing expected", m_data);
        end else begin
          mon_b = exp_q.pop_front();
          check("word_data", m_data, mon_b.data);
          check("word_last", m_last, mon_b.last);
        end
        words++;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
      if (done) begin
        done_cnt++;
        check("done_queue_empty", exp_q.size(), 0);
        if (lat_check) check("done_latency", cyc - start_edge, DRAIN_CYCLES);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    case (ready_mode)
      0: m_ready = 1'b1;
      1: begin
        m_ready     = (ready_phase == 0);
        ready_phase = (ready_phase + 1) % 3;
      end
      default: m_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic push_expected();
    logic [AW-1:0] a;
    ps_t           v;
    beat_t         b;
    for (int r = 0; r < NR; r++) begin
      a = AW'(BASE + r);
      for (int e = 0; e < MS; e++) begin
        v = mem[a][e*PSW +: PSW];
        if (RELU && v < 0) v = '0;
        b.data = v;
        b.last = (r == NR - 1) && (e == MS - 1);
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic fill_pattern();
    for (int r = 0; r < NR; r++)
      for (int e = 0; e < MS; e++)
        mem[AW'(BASE + r)][e*PSW +: PSW] = PSW'(r * MS + e);
  endtask

  task automatic fill_random();
    logic [AW-1:0] a0;
    for (int r = 0; r < NR; r++)
      for (int e = 0; e < MS; e++)
        mem[AW'(BASE + r)][e*PSW +: PSW] = PSW'($urandom);
    a0 = BASE;
    mem[a0][0*PSW +: PSW] = PSW'(-1);
    mem[a0][1*PSW +: PSW] = PSW'(5);
    mem[a0][2*PSW +: PSW] = PSW'(-8388608);
    mem[a0][3*PSW +: PSW] = PSW'(8388607);
  endtask

  task automatic run_drain(input bit chk_lat, input bit noise);
    int d0;
    d0 = done_cnt;
    push_expected();
    addr_seen.delete();
    words     = 0;
    lat_check = chk_lat;
    start     = 1'b1;
    tick();
    start_edge = cyc;
    start      = 1'b0;
    for (int i = 0; i < 20 * DRAIN_CYCLES && done_cnt == d0; i++) begin
      tick();
      start = (noise && busy && !done && $urandom_range(0, 5) == 0) || (noise && done);
    end
    start = 1'b0;
    repeat (4) tick();
    check("done_once", done_cnt - d0, 1);
    check("busy_after_drain", busy, 0);
    check("word_count", words, NR * MS);
    check("queue_empty", exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_valid"}, m_valid, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_last"}, m_last, 0);
    check({tag, "_data"}, m_data, 0);
    check({tag, "_addr"}, sram_address, BASE);
  endtask

  initial begin
    int d0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    rstn    = 1'b0;
    start   = 1'b1;
    m_ready = 1'b0;

    // Reset held with start asserted, then released with no start.
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rstn  = 1'b1;
    start = 1'b0;
    repeat (5) tick();
    check("idle_busy", busy, 0);
    check("idle_valid", m_valid, 0);

    // Full drain, ready always high, counting pattern.
    ready_mode = 0;
    fill_pattern();
    run_drain(1'b1, 1'b0);
    check("addr_count", addr_seen.size(), NR);
    for (int i = 0; i < NR; i++)
      if (i < addr_seen.size()) check("addr_step", addr_seen[i], AW'(BASE + i));

    // Backpressure 1,0,0 with start noise while busy and during FIN.
    ready_mode  = 1;
    ready_phase = 0;
    fill_random();
    run_drain(1'b0, 1'b1);

    // A second start from IDLE repeats the drain, random backpressure.
    ready_mode = 2;
    run_drain(1'b0, 1'b1);

    // Reset in the middle of the drain, at word 100.
    fill_random();
    push_expected();
    addr_seen.delete();
    words     = 0;
    lat_check = 1'b0;
    start     = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 20 * DRAIN_CYCLES && words < 100; i++) tick();
    check("reached_word_100", words >= 100, 1);
    d0   = done_cnt;
    rstn = 1'b0;
    exp_q.delete();
    #1;
    check_reset_outputs("midreset");
    repeat (3) tick();
    check("midreset_no_done", done_cnt, d0);
    rstn = 1'b1;
    repeat (2) tick();
    check("midreset_idle", busy, 0);

    // Restart after reset begins at address BASE, word 0.
    ready_mode = 0;
    run_drain(1'b1, 1'b0);
    if (addr_seen.size() > 0) check("restart_addr", addr_seen[0], BASE);
    else check("restart_addr_seen", addr_seen.size(), NR);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
